lfsr_prpg_core: RTL

LFSR_PRPG_CORE -- requirements
Module: lfsr_prpg_core

---
 rtl/lfsr_prpg_pkg.sv | 27 ++
 rtl/lfsr_prpg_core_lfsr_step.sv | 13 +
 rtl/lfsr_prpg_core.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/lfsr_prpg_pkg.sv
// lfsr_prpg_pkg: opcode and FSM state encodings shared by the LFSR pattern-generator core.
package lfsr_prpg_pkg;

    localparam int OPC_W = 6;

    typedef enum logic [OPC_W-1:0] {
        OP_CFG_TAP   = 6'h01,
        OP_INIT_L    = 6'h02,
        OP_RUN       = 6'h03,
        OP_STORE     = 6'h04,
        OP_LOAD      = 6'h05,
        OP_INIT_ADDR = 6'h06,
        OP_ADD_ADDR  = 6'h07,
        OP_STORE_HD  = 6'h09,
        OP_RUN_N     = 6'h0A,
        OP_HALT      = 6'h3F
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_RUN_N,
        S_HALT
    } state_e;

endpackage

// File: rtl/lfsr_prpg_core_lfsr_step.sv
// lfsr_step: one Galois-style LFSR step; the MSB feeds bit 0 and is XORed into every tapped bit above it.
module lfsr_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] tap,
    output logic [WIDTH-1:0] q_next
);

    // The zero in bit 0 of the mask discards tap[0].
    assign q_next = {q[WIDTH-2:0], q[WIDTH-1]} ^ (tap & {{(WIDTH-1){q[WIDTH-1]}}, 1'b0});

endmodule

// File: rtl/lfsr_prpg_core.sv
// lfsr_prpg_core: instruction-sequenced LFSR pattern generator with a small data memory.
// Define LFSR_PRPG_HD_EN to include the Hamming-distance unit and the STORE_HD opcode.
module lfsr_prpg_core
    import lfsr_prpg_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int MEM_DEPTH = 256,
    parameter  int PC_W      = 8,
    localparam int AW        = $clog2(MEM_DEPTH),
    localparam int HW        = $clog2(WIDTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   fetch_req,
    output logic [PC_W-1:0]        pc,
    input  logic [OPC_W+WIDTH-1:0] instr,
    input  logic                   instr_valid,
    output logic                   busy,
    output logic                   halted,
    output logic [WIDTH-1:0]       q,
    output logic [WIDTH-1:0]       q_next,
    output logic [HW-1:0]          hd,
    output logic [AW-1:0]          r_addr
);

    state_e                 state_q, state_d;
    logic [PC_W-1:0]        pc_q, pc_d;
    logic [WIDTH-1:0]       q_q, q_d;
    logic [WIDTH-1:0]       tap_q, tap_d;
    logic [AW-1:0]          r_addr_q, r_addr_d;
    logic [WIDTH-1:0]       count_q, count_d;
    logic [OPC_W+WIDTH-1:0] ir_q, ir_d;
    logic [WIDTH-1:0]       mem_q [MEM_DEPTH];
    logic                   mem_we;
    logic [WIDTH-1:0]       mem_wdata;
    opcode_e                opc;
    logic [WIDTH-1:0]       operand;

    assign opc     = opcode_e'(ir_q[OPC_W+WIDTH-1:WIDTH]);
    assign operand = ir_q[WIDTH-1:0];

    lfsr_step #(.WIDTH(WIDTH)) u_step (
        .q      (q_q),
        .tap    (tap_q),
        .q_next (q_next)
    );

`ifdef LFSR_PRPG_HD_EN
    logic [WIDTH-1:0] diff;
    assign diff = q_q ^ q_next;
    always_comb begin
        hd = '0;
        for (int i = 0; i < WIDTH; i++) hd = hd + HW'(diff[i]);
    end
`else
    assign hd = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            q_q      <= '0;
            tap_q    <= '0;
            r_addr_q <= '0;
            count_q  <= '0;
            ir_q     <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            q_q      <= q_d;
            tap_q    <= tap_d;
            r_addr_q <= r_addr_d;
            count_q  <= count_d;
            ir_q     <= ir_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && mem_we) mem_q[r_addr_q] <= mem_wdata;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_HALT: state_d = start ? S_FETCH : state_q;
            S_FETCH:        state_d = instr_valid ? S_EXEC : S_FETCH;
            S_EXEC:         state_d = (opc == OP_HALT) ? S_HALT :
                                      (opc == OP_RUN_N && operand != '0) ? S_RUN_N : S_FETCH;
            S_RUN_N:        state_d = (count_q == WIDTH'(1)) ? S_FETCH : S_RUN_N;
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pc_d      = pc_q;
        q_d       = q_q;
        tap_d     = tap_q;
        r_addr_d  = r_addr_q;
        count_d   = count_q;
        ir_d      = ir_q;
        mem_we    = 1'b0;
        mem_wdata = q_q;
        case (state_q)
            S_IDLE, S_HALT: pc_d = start ? '0 : pc_q;
            S_FETCH:        ir_d = instr_valid ? instr : ir_q;
            S_EXEC: begin
                pc_d = pc_q + 1'b1;
                case (opc)
                    OP_CFG_TAP:   tap_d = operand;
                    OP_INIT_L:    q_d = operand;
                    OP_RUN:       q_d = q_next;
                    OP_STORE:     mem_we = 1'b1;
                    OP_LOAD:      q_d = mem_q[r_addr_q];
                    OP_INIT_ADDR: r_addr_d = AW'(operand);
                    OP_ADD_ADDR:  r_addr_d = r_addr_q + AW'(operand);
`ifdef LFSR_PRPG_HD_EN
                    OP_STORE_HD: begin
                        mem_we    = 1'b1;
                        mem_wdata = WIDTH'(hd);
                    end
`endif
                    OP_RUN_N:     count_d = operand;
                    default:      ;
                endcase
            end
            S_RUN_N: begin
                q_d     = q_next;
                count_d = count_q - 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        fetch_req = (state_q == S_FETCH);
        busy      = (state_q != S_IDLE) && (state_q != S_HALT);
        halted    = (state_q == S_HALT);
    end

    assign pc     = pc_q;
    assign q      = q_q;
    assign r_addr = r_addr_q;

endmodule
